freq_bcd_conv: RTL and testbench

Converts the 20-bit binary frequency word from the cymometer (`data_fx`, in Hz) into seven packed BCD digits for the seven-segment/LCD display stage. It runs in the reference-clock domain (`clk_fs`), directly downstream of the cymometer. It samples `data_fx` on a periodic refresh tick or an explicit request, then runs an iterative shift-and-add-3 (double-dabble) conversion. It publishes the result with a one-cycle valid strobe.

---
 rtl/freq_pkg.sv | 18 +
 rtl/bcd_add3.sv | 14 +
 rtl/freq_bcd_conv.sv | 142 ++++++++++++++
 tb/tb_freq_bcd_conv.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/freq_pkg.sv
// Shared definitions for the frequency-to-BCD display path.
// Holds the converter word widths, the FSM state type and the blank digit code.
package freq_pkg;

  localparam int unsigned BIN_W  = 20;
  localparam int unsigned DIGITS = 7;
  localparam int unsigned BCD_W  = 28;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_e;

  // The display decoder renders this code as an unlit digit.
  localparam logic [3:0] BLANK_CODE = 4'hF;

endpackage

// File: rtl/bcd_add3.sv
// Single-digit double-dabble correction.
// Adds 3 to a BCD digit of 5 or more so that the following left shift carries
// correctly into the next decimal digit.
// Ports:
//   digit_i  4-bit BCD digit before correction
//   digit_o  4-bit corrected digit
module bcd_add3 (
  input  logic [3:0] digit_i,
  output logic [3:0] digit_o
);

  assign digit_o = (digit_i >= 4'd5) ? digit_i + 4'd3 : digit_i;

endmodule

// File: rtl/freq_bcd_conv.sv
// Binary-to-BCD converter for the frequency display.
// Samples the 20-bit frequency word on a periodic refresh tick or on request,
// runs a 20-step shift-and-add-3 conversion and publishes seven packed BCD
// digits with a one-cycle valid strobe.
// Optional build macro FREQ_BCD_BLANK_EN: replaces leading zero digits (never
// digit 0) with the blank code when the result is published.
// Ports:
//   clk_fs     reference clock, the only clock
//   rst        synchronous active-high reset
//   data_fx    measured frequency in Hz (same clock domain)
//   conv_req   single-cycle request to convert immediately
//   bcd_data   seven BCD digits, [3:0] units .. [27:24] millions
//   bcd_valid  one-cycle strobe marking new bcd_data
//   busy       high while a conversion is in progress
module freq_bcd_conv
  import freq_pkg::*;
#(
  parameter logic [25:0] CLK_FS      = 26'd50_000_000,
  parameter logic [25:0] REFRESH_CNT = CLK_FS / 26'd4
) (
  input  logic             clk_fs,
  input  logic             rst,
  input  logic [BIN_W-1:0] data_fx,
  input  logic             conv_req,
  output logic [BCD_W-1:0] bcd_data,
  output logic             bcd_valid,
  output logic             busy
);

  state_e           state_q, state_d;
  logic [25:0]      cnt_q, cnt_d;
  logic             pending_q, pending_d;
  logic [BIN_W-1:0] bin_sr_q, bin_sr_d;
  logic [BCD_W-1:0] bcd_sr_q, bcd_sr_d;
  logic [4:0]       iter_q, iter_d;
  logic [BCD_W-1:0] bcd_data_q, bcd_data_d;
  logic             bcd_valid_q, bcd_valid_d;
  logic             busy_q, busy_d;

  logic             tick;
  logic             req;
  logic [BCD_W-1:0] bcd_corr;
  logic [BCD_W-1:0] bcd_out;

  // Refresh counter free-runs regardless of converter state.
  assign tick  = (cnt_q == REFRESH_CNT - 26'd1);
  assign cnt_d = tick ? '0 : cnt_q + 26'd1;
  assign req   = tick | conv_req;

  for (genvar g = 0; g < DIGITS; g++) begin : gen_add3
    bcd_add3 u_bcd_add3 (
      .digit_i (bcd_sr_q[4*g +: 4]),
      .digit_o (bcd_corr[4*g +: 4])
    );
  end

`ifdef FREQ_BCD_BLANK_EN
  logic seen_nz;

  // Scan from the millions digit down; blank until the first non-zero digit.
  always_comb begin
    bcd_out = bcd_sr_q;
    seen_nz = 1'b0;
    for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
      if (bcd_sr_q[4*i +: 4] != 4'd0) seen_nz = 1'b1;
      if (!seen_nz) bcd_out[4*i +: 4] = BLANK_CODE;
    end
  end
`else
  assign bcd_out = bcd_sr_q;
`endif

  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q;
    bin_sr_d    = bin_sr_q;
    bcd_sr_d    = bcd_sr_q;
    iter_d      = iter_q;
    bcd_data_d  = bcd_data_q;
    bcd_valid_d = 1'b0;
    busy_d      = busy_q;

    unique case (state_q)
      IDLE: begin
        if (req || pending_q) begin
          // Pending requests sample data_fx now, not when they were raised.
          bin_sr_d  = data_fx;
          bcd_sr_d  = '0;
          iter_d    = '0;
          pending_d = 1'b0;
          busy_d    = 1'b1;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        {bcd_sr_d, bin_sr_d} = {bcd_corr, bin_sr_q} << 1;
        iter_d = iter_q + 5'd1;
        if (iter_q == 5'd19) state_d = DONE;
        if (req) pending_d = 1'b1;
      end
      DONE: begin
        bcd_data_d  = bcd_out;
        bcd_valid_d = 1'b1;
        busy_d      = 1'b0;
        state_d     = IDLE;
        if (req) pending_d = 1'b1;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_fs) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      pending_q   <= 1'b0;
      bin_sr_q    <= '0;
      bcd_sr_q    <= '0;
      iter_q      <= '0;
      bcd_data_q  <= '0;
      bcd_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pending_q   <= pending_d;
      bin_sr_q    <= bin_sr_d;
      bcd_sr_q    <= bcd_sr_d;
      iter_q      <= iter_d;
      bcd_data_q  <= bcd_data_d;
      bcd_valid_q <= bcd_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign bcd_data  = bcd_data_q;
  assign bcd_valid = bcd_valid_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_freq_bcd_conv.sv
// Directed bench for freq_bcd_conv with a 100-cycle refresh period.
module tb_freq_bcd_conv;

  logic        clk_fs = 1'b0;
  logic        rst = 1'b1;
  logic [19:0] data_fx = '0;
  logic        conv_req = 1'b0;
  logic [27:0] bcd_data;
  logic        bcd_valid;
  logic        busy;

  int n_vec  = 0;
  int n_miss = 0;
  int cyc    = 0;

`ifdef FREQ_BCD_BLANK_EN
  localparam logic [27:0] ExpZero  = 28'hFFFFFF0;
  localparam logic [27:0] Exp50k   = 28'hFF50000;
  localparam logic [27:0] Exp999   = 28'hFFFF999;
  localparam logic [27:0] Exp4321  = 28'hFFF4321;
  localparam logic [27:0] Exp7     = 28'hFFFFFF7;
  localparam logic [27:0] Exp86420 = 28'hFF86420;
`else
  localparam logic [27:0] ExpZero  = 28'h0000000;
  localparam logic [27:0] Exp50k   = 28'h0050000;
  localparam logic [27:0] Exp999   = 28'h0000999;
  localparam logic [27:0] Exp4321  = 28'h0004321;
  localparam logic [27:0] Exp7     = 28'h0000007;
  localparam logic [27:0] Exp86420 = 28'h0086420;
`endif

  always #5 clk_fs = ~clk_fs;

  freq_bcd_conv #(
    .CLK_FS      (26'd400),
    .REFRESH_CNT (26'd100)
  ) dut (
    .clk_fs    (clk_fs),
    .rst       (rst),
    .data_fx   (data_fx),
    .conv_req  (conv_req),
    .bcd_data  (bcd_data),
    .bcd_valid (bcd_valid),
    .busy      (busy)
  );

  task automatic step();
    @(posedge clk_fs);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    conv_req = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic wait_valid(input int budget, output bit seen);
    seen = 1'b0;
    for (int k = 0; k < budget && !seen; k++) begin
      step();
      if (bcd_valid === 1'b1) seen = 1'b1;
    end
  endtask

  task automatic pulse_req(input logic [19:0] val);
    data_fx  = val;
    conv_req = 1'b1;
    step();
    conv_req = 1'b0;
  endtask

  task automatic test_reset();
    data_fx = 20'd12345;
    conv_req = 1'b0;
    rst = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      n_vec++;
      if ({bcd_data, bcd_valid, busy} !== 30'd0) begin
        n_miss++;
        $display("FAIL reset_hold[%0d]: got data=%h valid=%b busy=%b, want 0/0/0",
                 k, bcd_data, bcd_valid, busy);
      end
    end
    rst = 1'b0;
    for (int k = 0; k < 20; k++) begin
      step();
      n_vec++;
      if (bcd_valid !== 1'b0 || busy !== 1'b0) begin
        n_miss++;
        $display("FAIL reset_quiet[%0d]: got valid=%b busy=%b, want 0/0", k, bcd_valid, busy);
      end
    end
  endtask

  task automatic test_max();
    bit bad;
    do_reset();
    pulse_req(20'd1048575);
    n_vec++;
    if (busy !== 1'b1 || bcd_valid !== 1'b0) begin
      n_miss++;
      $display("FAIL max_e0: got busy=%b valid=%b, want 1/0", busy, bcd_valid);
    end
    bad = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (busy !== 1'b1 || bcd_valid !== 1'b0) bad = 1'b1;
    end
    n_vec++;
    if (bad) begin
      n_miss++;
      $display("FAIL max_window: got busy drop or early valid in E1..E20, want busy=1 valid=0");
    end
    step();
    n_vec++;
    if (bcd_valid !== 1'b1 || busy !== 1'b0 || bcd_data !== 28'h1048575) begin
      n_miss++;
      $display("FAIL max_e21: got valid=%b busy=%b data=%h, want 1/0/1048575",
               bcd_valid, busy, bcd_data);
    end
    step();
    n_vec++;
    if (bcd_valid !== 1'b0 || bcd_data !== 28'h1048575) begin
      n_miss++;
      $display("FAIL max_hold: got valid=%b data=%h, want 0/1048575", bcd_valid, bcd_data);
    end
  endtask

  task automatic test_zero_blank();
    bit seen;
    do_reset();
    pulse_req(20'd0);
    wait_valid(30, seen);
    n_vec++;
    if (!seen || bcd_data !== ExpZero) begin
      n_miss++;
      $display("FAIL zero: got seen=%b data=%h, want 1/%h", seen, bcd_data, ExpZero);
    end
    pulse_req(20'd50000);
    wait_valid(30, seen);
    n_vec++;
    if (!seen || bcd_data !== Exp50k) begin
      n_miss++;
      $display("FAIL fifty_k: got seen=%b data=%h, want 1/%h", seen, bcd_data, Exp50k);
    end
  endtask

  task automatic test_back_to_back();
    bit seen;
    int t1;
    do_reset();
    pulse_req(20'd999);
    for (int k = 0; k < 5; k++) step();
    pulse_req(20'd4321);
    wait_valid(30, seen);
    t1 = cyc;
    n_vec++;
    if (!seen || bcd_data !== Exp999) begin
      n_miss++;
      $display("FAIL b2b_first: got seen=%b data=%h, want 1/%h", seen, bcd_data, Exp999);
    end
    wait_valid(40, seen);
    n_vec++;
    if (!seen || bcd_data !== Exp4321 || cyc - t1 != 22) begin
      n_miss++;
      $display("FAIL b2b_second: got seen=%b data=%h gap=%0d, want 1/%h/22",
               seen, bcd_data, cyc - t1, Exp4321);
    end
  endtask

  task automatic test_refresh();
    bit seen;
    int t0;
    do_reset();
    data_fx = 20'd7;
    t0 = cyc;
    wait_valid(200, seen);
    n_vec++;
    if (!seen || bcd_data !== Exp7 || cyc - t0 != 121) begin
      n_miss++;
      $display("FAIL refresh_first: got seen=%b data=%h at=%0d, want 1/%h/121",
               seen, bcd_data, cyc - t0, Exp7);
    end
    for (int r = 0; r < 2; r++) begin
      t0 = cyc;
      wait_valid(150, seen);
      n_vec++;
      if (!seen || bcd_data !== Exp7 || cyc - t0 != 100) begin
        n_miss++;
        $display("FAIL refresh_period[%0d]: got seen=%b data=%h gap=%0d, want 1/%h/100",
                 r, seen, bcd_data, cyc - t0, Exp7);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit seen;
    do_reset();
    pulse_req(20'd55555);
    for (int k = 0; k < 10; k++) step();
    rst = 1'b1;
    step();
    n_vec++;
    if (busy !== 1'b0 || bcd_data !== 28'd0 || bcd_valid !== 1'b0) begin
      n_miss++;
      $display("FAIL midrst_clear: got busy=%b data=%h valid=%b, want 0/0/0",
               busy, bcd_data, bcd_valid);
    end
    rst = 1'b0;
    wait_valid(25, seen);
    n_vec++;
    if (seen) begin
      n_miss++;
      $display("FAIL midrst_nostrobe: got strobe=%b, want 0", seen);
    end
    pulse_req(20'd86420);
    wait_valid(30, seen);
    n_vec++;
    if (!seen || bcd_data !== Exp86420) begin
      n_miss++;
      $display("FAIL midrst_next: got seen=%b data=%h, want 1/%h", seen, bcd_data, Exp86420);
    end
  endtask

  initial begin
    test_reset();
    test_max();
    test_zero_blank();
    test_back_to_back();
    test_refresh();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
